// File: rtl/pic16_pkg.sv
// Shared OPTION-register field positions and prescaler terminal-count helper for the PIC16 timer front end.
// Pure definitions: no latency, no flow control.
package pic16_pkg;

  localparam int OPT_T0CS  = 5;
  localparam int OPT_T0SE  = 4;
  localparam int OPT_PSA   = 3;
  localparam int OPT_PS_HI = 2;
  localparam int OPT_PS_LO = 0;

  // TMR0 gets 1:2^(PS+1); the watchdog gets 1:2^PS, so PS=0 on the WDT is a straight pass-through.
  function automatic logic [31:0] presc_term(input logic [2:0] ps, input logic psa);
    logic [31:0] sh;
    sh = {29'd0, ps} + (psa ? 32'd0 : 32'd1);
    return (32'd1 << sh) - 32'd1;
  endfunction

endpackage

// File: rtl/pic_edge_sync.sv
// Synchronises the asynchronous T0CKI pin and emits 1-clk rise/fall pulses, muted for SYNC_STAGES+1 clk after reset.
// Edge pulse appears SYNC_STAGES clk after the pin is sampled; no backpressure.
module pic_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  localparam int HOLD = SYNC_STAGES + 1;
  localparam int HW   = $clog2(HOLD + 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [HW-1:0]          r_hold;
  logic                   w_armed;
  logic                   w_synced;

  assign w_synced = r_sync[SYNC_STAGES-1];
  // The chain and edge history reset to 0, so a pin already high at release would look like a rising edge.
  assign w_armed  = (r_hold == HW'(HOLD));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_hold <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= w_synced;
      if (!w_armed) r_hold <= r_hold + 1'b1;
    end
  end

  assign o_rise = w_armed & w_synced & ~r_prev;
  assign o_fall = w_armed & ~w_synced & r_prev;

endmodule

// File: rtl/pic_tmr0_wdt_prescaler.sv
// TMR0 source select, shared TMR0/WDT prescaler and watchdog base counter feeding the PIC16F54 core; WDT built only with PIC_WDT_EN.
// tmr0_inc/wdtmr are registered 1-clk pulses one clk after the qualifying event; no backpressure, every event is consumed.
module pic_tmr0_wdt_prescaler
  import pic16_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int PRESC_W     = 8,
  parameter int WDT_BASE_W  = 18
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cyc_en,
  input  logic [7:0] option_in,
  input  logic       t0cki,
  input  logic       tmr0_wr,
  input  logic       clrwdt,
  output logic       tmr0_inc,
  output logic       wdtmr
);

  logic               w_rise;
  logic               w_fall;
  logic               w_src;
  logic               w_psa;
  logic [2:0]         w_ps;
  logic               w_opt_chg;
  logic               w_tc;
  logic               w_psc_evt;
  logic               w_psc_clr;
  logic [1:0]         w_opt_unused;
  logic [3:0]         r_opt_prev;
  logic [PRESC_W-1:0] r_psc;
  logic               r_tmr0_inc;

  pic_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(t0cki),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  assign w_opt_unused = option_in[7:6];
  assign w_psa     = option_in[OPT_PSA];
  assign w_ps      = option_in[OPT_PS_HI:OPT_PS_LO];
  assign w_opt_chg = (option_in[OPT_PSA:OPT_PS_LO] != r_opt_prev);
  assign w_src     = option_in[OPT_T0CS] ? (option_in[OPT_T0SE] ? w_fall : w_rise) : cyc_en;
  assign w_tc      = ({{(32-PRESC_W){1'b0}}, r_psc} == presc_term(w_ps, w_psa));

`ifdef PIC_WDT_EN
  logic [WDT_BASE_W-1:0] r_wdt_cnt;
  logic                  w_base_tick;
  logic                  r_wdtmr;

  assign w_base_tick = &r_wdt_cnt;
  assign w_psc_evt   = w_psa ? w_base_tick : w_src;
  assign w_psc_clr   = w_opt_chg | (tmr0_wr & ~w_psa) | (clrwdt & w_psa);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdt_cnt <= '0;
      r_wdtmr   <= 1'b0;
    end else begin
      r_wdt_cnt <= clrwdt ? '0 : r_wdt_cnt + 1'b1;
      // A CLRWDT landing on the terminal event must suppress the time-out.
      r_wdtmr   <= w_psa ? (w_psc_evt & w_tc & ~w_psc_clr) : (w_base_tick & ~clrwdt);
    end
  end

  assign wdtmr = r_wdtmr;
`else
  logic [WDT_BASE_W:0] w_wdt_unused;

  assign w_wdt_unused = {clrwdt, {WDT_BASE_W{1'b0}}};
  assign w_psc_evt    = ~w_psa & w_src;
  assign w_psc_clr    = w_opt_chg | (tmr0_wr & ~w_psa);
  assign wdtmr        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opt_prev <= '0;
      r_psc      <= '0;
      r_tmr0_inc <= 1'b0;
    end else begin
      r_opt_prev <= option_in[OPT_PSA:OPT_PS_LO];
      if (w_psc_clr)      r_psc <= '0;
      else if (w_psc_evt) r_psc <= w_tc ? '0 : r_psc + 1'b1;
      r_tmr0_inc <= w_psa ? w_src : (w_psc_evt & w_tc & ~w_psc_clr);
    end
  end

  assign tmr0_inc = r_tmr0_inc;

endmodule

// File: tb/tb_pic_tmr0_wdt_prescaler.sv
// Self-checking bench for pic_tmr0_wdt_prescaler: vector table, directed timer/WDT sequences and a random run
// against an event-counting reference model.
module tb_pic_tmr0_wdt_prescaler;

  localparam int S  = 2;
  localparam int PW = 8;
  localparam int WB = 4;
`ifdef PIC_WDT_EN
  localparam bit WDT = 1'b1;
`else
  localparam bit WDT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cyc_en = 1'b0;
  logic [7:0] option_in = 8'h00;
  logic       t0cki = 1'b0;
  logic       tmr0_wr = 1'b0;
  logic       clrwdt = 1'b0;
  logic       tmr0_inc;
  logic       wdtmr;

  always #5 clk = ~clk;

  pic_tmr0_wdt_prescaler #(.SYNC_STAGES(S), .PRESC_W(PW), .WDT_BASE_W(WB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cyc_en   (cyc_en),
    .option_in(option_in),
    .t0cki    (t0cki),
    .tmr0_wr  (tmr0_wr),
    .clrwdt   (clrwdt),
    .tmr0_inc (tmr0_inc),
    .wdtmr    (wdtmr)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state: cycle index since reset release, pin history, prescaler event count, last WDT clear.
  int         m_n;
  bit         m_pin[$];
  logic [7:0] m_opt_prev;
  int         m_psc;
  int         m_wdt_c;
  int         inc_cyc[$];
  int         wdt_cyc[$];

  typedef struct {
    logic [7:0] opt;
    logic       cyc;
    logic       wr;
    logic       exp_inc;
    logic       exp_wdt;
  } vec_t;
  vec_t tbl[15];

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%b exp=%b", name, m_n, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_n = 0;
    m_pin.delete();
    m_opt_prev = 8'h00;
    m_psc = 0;
    m_wdt_c = 0;
    inc_cyc.delete();
    wdt_cyc.delete();
  endtask

  // Outputs seen after the next edge, from the inputs currently driven (cycle m_n).
  task automatic model_step(output bit ei, output bit ew);
    bit syn, prv, rise, fall, src, psa, tick, clr_p, evt;
    int ps, ratio;
    m_pin.push_back(t0cki);
    syn  = (m_n >= S) ? m_pin[m_n-S] : 1'b0;
    prv  = (m_n >= S + 1) ? m_pin[m_n-S-1] : 1'b0;
    rise = (m_n >= S + 1) && syn && !prv;
    fall = (m_n >= S + 1) && !syn && prv;
    src  = option_in[5] ? (option_in[4] ? fall : rise) : cyc_en;
    psa  = option_in[3];
    ps   = int'(option_in[2:0]);
    tick = WDT && (((m_n - m_wdt_c) % (1 << WB)) == (1 << WB) - 1) && !clrwdt;
    clr_p = (option_in[3:0] != m_opt_prev[3:0]) || (tmr0_wr && !psa) || (WDT && clrwdt && psa);
    ei = 1'b0;
    ew = 1'b0;
    if (psa) begin
      ei = src;
      evt = tick;
      ratio = 1 << ps;
    end else begin
      ew = tick;
      evt = src;
      ratio = 1 << (ps + 1);
    end
    if (clr_p) m_psc = 0;
    else if (evt) begin
      m_psc++;
      if (m_psc == ratio) begin
        m_psc = 0;
        if (psa) ew = 1'b1;
        else ei = 1'b1;
      end
    end
    if (WDT && clrwdt) m_wdt_c = m_n + 1;
    m_opt_prev = option_in;
    m_n++;
  endtask

  task automatic tick(input string tag);
    bit ei, ew;
    model_step(ei, ew);
    @(posedge clk);
    #1;
    chk({tag, "_inc"}, tmr0_inc, ei);
    chk({tag, "_wdt"}, wdtmr, ew);
    if (tmr0_inc) inc_cyc.push_back(m_n);
    if (wdtmr) wdt_cyc.push_back(m_n);
  endtask

  task automatic run_to(input string tag, input int cyc);
    while (m_n < cyc) tick(tag);
  endtask

  task automatic do_reset(input logic [7:0] opt, input logic pin);
    rst_n = 1'b0;
    option_in = opt;
    t0cki = pin;
    cyc_en = 1'b0;
    tmr0_wr = 1'b0;
    clrwdt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_inc", tmr0_inc, 1'b0);
    chk("rst_wdt", wdtmr, 1'b0);
    rst_n = 1'b1;
    model_reset();
  endtask

  function automatic int first_or_neg(input int q[$]);
    return (q.size() > 0) ? q[0] : -1;
  endfunction

  initial begin
    int edge_cyc[17];
    tbl[0]  = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{8'h08, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{8'h08, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{8'h08, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{8'h01, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{8'h01, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{8'h01, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{8'h01, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{8'h01, 1'b1, 1'b0, 1'b1, 1'b0};

    // Pin high through reset release must not count.
    do_reset(8'h28, 1'b1);
    repeat (10) tick("por");
    chk_int("por_pulses", inc_cyc.size(), 0);

    do_reset(8'h00, 1'b0);
    for (int i = 0; i < 15; i++) begin
      option_in = tbl[i].opt;
      cyc_en = tbl[i].cyc;
      tmr0_wr = tbl[i].wr;
      tick("tbl_model");
      chk("tbl_inc", tmr0_inc, tbl[i].exp_inc);
      chk("tbl_wdt", wdtmr, tbl[i].exp_wdt);
    end
    tmr0_wr = 1'b0;

    do_reset(8'h08, 1'b0);
    for (int i = 0; i < 100; i++) begin
      cyc_en = 1'b1;
      tick("cyc");
      cyc_en = 1'b0;
      repeat (3) tick("cyc");
    end
    tick("cyc");
    chk_int("cyc_pulses", inc_cyc.size(), 100);

    do_reset(8'h22, 1'b0);
    repeat (5) tick("rise8");
    for (int e = 1; e <= 16; e++) begin
      t0cki = 1'b1;
      edge_cyc[e] = m_n;
      repeat (5) tick("rise8");
      t0cki = 1'b0;
      repeat (5) tick("rise8");
    end
    repeat (5) tick("rise8");
    chk_int("rise8_pulses", inc_cyc.size(), 2);
    chk_int("rise8_lat1", first_or_neg(inc_cyc) - edge_cyc[8], S + 1);
    chk_int("rise8_lat2", (inc_cyc.size() > 1 ? inc_cyc[1] : -1) - edge_cyc[16], S + 1);

    do_reset(8'h32, 1'b0);
    repeat (5) tick("fall8");
    for (int e = 1; e <= 13; e++) begin
      t0cki = 1'b1;
      repeat (5) tick("fall8");
      t0cki = 1'b0;
      edge_cyc[e] = m_n;
      repeat (5) tick("fall8");
      if (e == 5) begin
        tmr0_wr = 1'b1;
        tick("fall8");
        tmr0_wr = 1'b0;
      end
    end
    repeat (5) tick("fall8");
    chk_int("fall8_pulses", inc_cyc.size(), 1);
    chk_int("fall8_lat", first_or_neg(inc_cyc) - edge_cyc[13], S + 1);

    do_reset(8'h0B, 1'b0);
    run_to("wdt", 140);
    chk_int("wdt_first", first_or_neg(wdt_cyc), WDT ? 128 : -1);

    do_reset(8'h0B, 1'b0);
    run_to("wdt_clr", 99);
    clrwdt = 1'b1;
    tick("wdt_clr");
    clrwdt = 1'b0;
    run_to("wdt_clr", 240);
    chk_int("wdt_clr_count", wdt_cyc.size(), WDT ? 1 : 0);
    chk_int("wdt_clr_first", first_or_neg(wdt_cyc), WDT ? 228 : -1);

    do_reset(8'h0B, 1'b0);
    run_to("wdt_coin", 127);
    clrwdt = 1'b1;
    tick("wdt_coin");
    clrwdt = 1'b0;
    run_to("wdt_coin", 260);
    chk_int("wdt_coin_first", first_or_neg(wdt_cyc), WDT ? 256 : -1);

    do_reset(8'h0B, 1'b0);
    run_to("wdt_ps", 60);
    option_in = 8'h0A;
    run_to("wdt_ps", 130);
    chk_int("wdt_ps_first", first_or_neg(wdt_cyc), WDT ? 112 : -1);

    do_reset(8'($urandom), 1'b0);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 63) == 0) option_in = 8'($urandom);
      cyc_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) t0cki = ~t0cki;
      tmr0_wr = ($urandom_range(0, 15) == 0);
      clrwdt = ($urandom_range(0, 299) == 0);
      tick("rand");
      if (i == 2000) begin
        rst_n = 1'b0;
        #2;
        chk("async_rst_inc", tmr0_inc, 1'b0);
        chk("async_rst_wdt", wdtmr, 1'b0);
        do_reset(option_in, t0cki);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
